// File: rtl/prg_uploader_pkg.sv
// Shared types and default SDRAM addresses for the PRG upload/download path.
package prg_uploader_pkg;

    typedef logic [24:0] addr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PTR_LO,
        S_PTR_HI,
        S_CHECK,
        S_FETCH,
        S_HOLD,
        S_CSUM,
        S_DONE
    } state_t;

    // Read request handed to the read sequencer
    typedef struct packed {
        logic  start;
        addr_t addr;
    } rd_req_t;

    localparam addr_t       DEF_PRG_START_ADDR = 25'h15608;
    localparam addr_t       DEF_PTR_PROGND     = 25'h155e4;
    localparam addr_t       DEF_RAM_BASE       = 25'h10000;
    localparam logic [15:0] DEF_MAX_LEN        = 16'hA000;

    function automatic logic is_read_state(input state_t s);
        return (s == S_PTR_LO) || (s == S_PTR_HI) || (s == S_FETCH);
    endfunction

endpackage

// File: rtl/prg_uploader_mem_read_step.sv
// One SDRAM byte read: first ena after start issues, second ena captures.
module mem_read_step
    import prg_uploader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  rd_req_t    req,
    input  logic       ena,
    input  logic [7:0] mem_din,
    output addr_t      mem_addr,
    output logic       mem_rd,
    output logic [7:0] data,
    output logic       data_valid
);

    logic issued;

    // Address latched at start and held until capture; data_valid pulses one clk
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            issued     <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (req.start) begin
                mem_addr <= req.addr;
                mem_rd   <= 1'b1;
                issued   <= 1'b0;
            end else if (mem_rd && ena) begin
                if (!issued) begin
                    issued <= 1'b1;
                end else begin
                    data       <= mem_din;
                    data_valid <= 1'b1;
                    mem_rd     <= 1'b0;
                    issued     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/prg_uploader.sv
// Streams the BASIC program in LM80C RAM back out of SDRAM (file save).
// Optional PRG_UPLOADER_CHECKSUM_EN appends a two's-complement checksum byte.
module prg_uploader
    import prg_uploader_pkg::*;
#(
    parameter addr_t       PRG_START_ADDR = DEF_PRG_START_ADDR,
    parameter addr_t       PTR_PROGND     = DEF_PTR_PROGND,
    parameter addr_t       RAM_BASE       = DEF_RAM_BASE,
    parameter logic [15:0] MAX_LEN        = DEF_MAX_LEN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ena,
    input  logic        trigger,
    output logic        busy,
    output logic        done,
    output logic        empty,
    output logic [15:0] len,
    output logic [24:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_din,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last
);

    state_t      state, state_n;
    logic        trig_q, trig_rise;
    logic [15:0] ptr, cnt;
    addr_t       addr;
    logic [7:0]  data_q, csum;
    rd_req_t     rd_req;
    logic [7:0]  rd_data;
    logic        rd_valid;
    addr_t       end_addr, diff;
    logic        chk_fail;

    assign trig_rise = trigger & ~trig_q;
    assign end_addr  = RAM_BASE + addr_t'(ptr);
    assign diff      = end_addr - PRG_START_ADDR;
    assign chk_fail  = (end_addr <= PRG_START_ADDR) || (diff > addr_t'(MAX_LEN));

    mem_read_step u_rd (
        .clk        (clk),
        .reset      (reset),
        .req        (rd_req),
        .ena        (ena),
        .mem_din    (mem_din),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .data       (rd_data),
        .data_valid (rd_valid)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next state and read-request generation on entry to a read state
    always_comb begin
        state_n     = state;
        rd_req      = '0;
        case (state)
            S_IDLE:   if (trig_rise) state_n = S_PTR_LO;
            S_PTR_LO: if (rd_valid)  state_n = S_PTR_HI;
            S_PTR_HI: if (rd_valid)  state_n = S_CHECK;
            S_CHECK:  state_n = chk_fail ? S_DONE : S_FETCH;
            S_FETCH:  if (rd_valid)  state_n = S_HOLD;
            S_HOLD: begin
                if (out_ready) begin
                    if (cnt != 16'd1) state_n = S_FETCH;
`ifdef PRG_UPLOADER_CHECKSUM_EN
                    else              state_n = S_CSUM;
`else
                    else              state_n = S_DONE;
`endif
                end
            end
            S_CSUM:   if (out_ready) state_n = S_DONE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase

        rd_req.start = is_read_state(state_n) && (state_n != state);
        case (state_n)
            S_PTR_LO: rd_req.addr = PTR_PROGND;
            S_PTR_HI: rd_req.addr = PTR_PROGND + 25'd1;
            default:  rd_req.addr = (state == S_CHECK) ? PRG_START_ADDR : addr + 25'd1;
        endcase
    end

    // Datapath: pointer assembly, length check, byte counter and running sum
    always_ff @(posedge clk) begin
        if (reset) begin
            trig_q <= trigger;
            ptr    <= '0;
            len    <= '0;
            cnt    <= '0;
            addr   <= '0;
            data_q <= '0;
            empty  <= 1'b0;
            csum   <= '0;
        end else begin
            trig_q <= trigger;
            case (state)
                S_IDLE: begin
                    if (trig_rise) begin
                        empty <= 1'b0;
                        csum  <= '0;
                    end
                end
                S_PTR_LO: if (rd_valid) ptr[7:0]  <= rd_data;
                S_PTR_HI: if (rd_valid) ptr[15:8] <= rd_data;
                S_CHECK: begin
                    len <= diff[15:0];
                    if (chk_fail) begin
                        empty <= 1'b1;
                    end else begin
                        cnt  <= diff[15:0];
                        addr <= PRG_START_ADDR;
                    end
                end
                S_FETCH: if (rd_valid) data_q <= rd_data;
                S_HOLD: begin
                    if (out_ready) begin
                        addr <= addr + 25'd1;
                        cnt  <= cnt - 16'd1;
                        csum <= csum + data_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stream and status outputs decoded from the state register
    always_comb begin
        busy      = (state != S_IDLE) && (state != S_DONE);
        done      = (state == S_DONE);
        out_valid = (state == S_HOLD) || (state == S_CSUM);
        out_data  = (state == S_CSUM) ? 8'(~csum + 8'd1) : data_q;
`ifdef PRG_UPLOADER_CHECKSUM_EN
        out_last  = (state == S_CSUM);
`else
        out_last  = (state == S_HOLD) && (cnt == 16'd1);
`endif
    end

endmodule

// File: tb/tb_prg_uploader.sv
// Scoreboard bench for prg_uploader: expected bytes queued at trigger, popped on transfer.
module tb_prg_uploader;
    import prg_uploader_pkg::*;

    logic        clk = 1'b0, reset = 1'b1, ena = 1'b0, trigger = 1'b0, out_ready = 1'b0;
    logic        busy, done, empty, mem_rd, out_valid, out_last;
    logic [15:0] len;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din, out_data;

    logic [7:0]  p_lo = 8'h00, p_hi = 8'h00;
    logic [7:0]  dmem [0:15];

    int          n_chk = 0, n_err = 0, done_cnt = 0, ecnt = 0;
    bit          valid_seen = 1'b0;
    logic [8:0]  exp_q [$];

    prg_uploader dut (
        .clk(clk), .reset(reset), .ena(ena), .trigger(trigger),
        .busy(busy), .done(done), .empty(empty), .len(len),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_din(mem_din),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    // SDRAM model: end pointer bytes plus a small program window
    always_comb begin
        mem_din = 8'h00;
        if (mem_addr == 25'h155e4)      mem_din = p_lo;
        else if (mem_addr == 25'h155e5) mem_din = p_hi;
        else if (mem_addr >= 25'h15608 && mem_addr < 25'h15618)
            mem_din = dmem[4'(mem_addr - 25'h15608)];
    end

    // Memory-slot strobe every third clock
    initial forever begin
        @(posedge clk); #1;
        ena  = (ecnt == 2);
        ecnt = (ecnt + 1) % 3;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Output monitor: pop the scoreboard on every transfer
    always @(negedge clk) begin
        if (!reset) begin
            if (done) done_cnt++;
            if (out_valid) valid_seen = 1'b1;
            if (out_last) chk("last_needs_valid", 32'(out_valid), 32'd1);
            if (out_valid && out_ready) begin
                chk("stream_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("stream_byte", {23'b0, out_last, out_data}, {23'b0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input int n);
        logic [7:0] sum = 8'h00;
        bit         ck  = 1'b0;
`ifdef PRG_UPLOADER_CHECKSUM_EN
        ck = 1'b1;
`endif
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1) && !ck, dmem[i]});
            sum = sum + dmem[i];
        end
        if (ck) exp_q.push_back({1'b1, 8'(~sum + 8'd1)});
    endtask

    task automatic start_upload();
        trigger = 1'b0;
        tick(2);
        valid_seen = 1'b0;
        trigger = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_rd", {7'b0, mem_rd, mem_addr}, {7'b0, 1'b1, 25'h155e4});
    endtask

    task automatic wait_done(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        chk("done_seen", 32'(ok), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1'b1; break; end
        end
        chk("valid_seen", 32'(ok), 32'd1);
    endtask

    task automatic load(input logic [15:0] p);
        p_lo = p[7:0];
        p_hi = p[15:8];
        dmem[0] = 8'h11; dmem[1] = 8'h22; dmem[2] = 8'h33;
    endtask

    int d0;
    logic [24:0] a0;

    initial begin
        for (int i = 0; i < 16; i++) dmem[i] = 8'(8'hA0 + i);

        // Reset state
        tick(3);
        @(negedge clk);
        chk("rst_flags", {26'b0, busy, done, empty, mem_rd, out_valid, out_last}, 32'd0);
        chk("rst_len", 32'(len), 32'd0);
        reset = 1'b0;
        tick(2);

        // Normal three-byte upload
        load(16'h560B);
        out_ready = 1'b1;
        push_stream(3);
        d0 = done_cnt;
        start_upload();
        wait_done(500);
        chk("norm_empty", 32'(empty), 32'd0);
        chk("norm_len", 32'(len), 32'd3);
        chk("norm_busy_at_done", 32'(busy), 32'd0);
        tick(3);
        chk("norm_drained", 32'(exp_q.size()), 32'd0);
        chk("norm_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Empty: end equal to start, end below start, length over MAX_LEN
        load(16'h5608);
        start_upload();
        wait_done(200);
        chk("empty0_flag", 32'(empty), 32'd1);
        chk("empty0_len", 32'(len), 32'd0);
        chk("empty0_novalid", 32'(valid_seen), 32'd0);
        load(16'h5000);
        start_upload();
        wait_done(200);
        chk("below_flag", 32'(empty), 32'd1);
        chk("below_len", 32'(len), 32'hF9F8);
        chk("below_novalid", 32'(valid_seen), 32'd0);
        load(16'hF609);
        start_upload();
        wait_done(200);
        chk("toolong_flag", 32'(empty), 32'd1);
        chk("toolong_len", 32'(len), 32'hA001);
        chk("toolong_novalid", 32'(valid_seen), 32'd0);

        // Backpressure on byte 2
        load(16'h560B);
        push_stream(3);
        out_ready = 1'b0;
        start_upload();
        chk("bp_empty_cleared", 32'(empty), 32'd0);
        wait_valid(200);
        chk("bp_byte1", 32'(out_data), 32'h11);
        @(posedge clk); #1; out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        wait_valid(200);
        a0 = mem_addr;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_hold", {15'b0, out_valid, mem_rd, out_data, 7'b0}, {15'b0, 1'b1, 1'b0, 8'h22, 7'b0});
            chk("bp_addr", 32'(mem_addr), 32'(a0));
        end
        @(posedge clk); #1; out_ready = 1'b1;
        wait_done(500);
        tick(2);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Retrigger mid-stream and trigger held high after done
        push_stream(3);
        d0 = done_cnt;
        start_upload();
        wait_valid(200);
        tick(1); trigger = 1'b0;
        tick(1); trigger = 1'b1;
        wait_done(500);
        tick(40);
        chk("retrig_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("retrig_idle", 32'(busy), 32'd0);
        chk("retrig_drained", 32'(exp_q.size()), 32'd0);

        // Reset during HOLD aborts; a new trigger restarts from byte 0
        push_stream(3);
        out_ready = 1'b0;
        d0 = done_cnt;
        start_upload();
        wait_valid(200);
        @(posedge clk); #1; reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("abort_flags", {26'b0, busy, done, empty, mem_rd, out_valid, out_last}, 32'd0);
        chk("abort_data", {out_data, len}, 32'd0);
        chk("abort_addr", 32'(mem_addr), 32'd0);
        tick(1); reset = 1'b0;
        tick(2);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        out_ready = 1'b1;
        push_stream(3);
        start_upload();
        wait_done(500);
        tick(2);
        chk("restart_len", 32'(len), 32'd3);
        chk("restart_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
